// File: rtl/tx_buffer.sv
// Byte+config FIFO feeding a UART launcher: push-to-tx_start latency 2 cycles; pushes while full are dropped,
// entries released on the rising edge of tx_done_i. Optional sticky overflow flag via TX_BUFFER_OVERFLOW_EN.
module tx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       wr_en_i,
  input  logic [7:0]                 wr_data_i,
  input  logic [4:0]                 wr_conf_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [7:0]                 tx_data_o,
  output logic [4:0]                 tx_conf_o,
  output logic                       tx_start_o,
  input  logic                       tx_done_i,
  output logic                       busy_o
`ifdef TX_BUFFER_OVERFLOW_EN
  ,
  input  logic                       ovf_clr_i,
  output logic                       overflow_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01
  } state_e;

  state_e              state_q;
  logic [12:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                tx_done_q;
  logic [7:0]          tx_data_q;
  logic [4:0]          tx_conf_q;
  logic                tx_start_q;
  logic                full, empty, push, pop, done_rise;
  logic [12:0]         head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = wr_en_i && !full;
  assign done_rise = tx_done_i && !tx_done_q;
  assign head      = mem_q[rd_ptr_q];

  // A flush empties the queue this cycle, so nothing may be launched from it.
  assign pop = !flush_i && !empty &&
               ((state_q == IDLE) || ((state_q == ACTIVE) && done_rise));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= {wr_conf_i, wr_data_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_done_q <= tx_done_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_conf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= head[7:0];
            tx_conf_q  <= head[12:8];
            tx_start_q <= 1'b1;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (done_rise) begin
            if (pop) begin
              tx_data_q  <= head[7:0];
              tx_conf_q  <= head[12:8];
              tx_start_q <= 1'b1;
            end else begin
              tx_start_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef TX_BUFFER_OVERFLOW_EN
  logic overflow_q;

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_q <= 1'b0;
    end else if (wr_en_i && full) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr_i) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow_o = overflow_q;
`endif

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign tx_data_o  = tx_data_q;
  assign tx_conf_o  = tx_conf_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = (state_q == ACTIVE);

endmodule

// File: tb/tb_tx_buffer.sv
// Bench for tx_buffer: directed vector table, hand sequences for fill/flush/reset, random traffic vs queue model.
module tb_tx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              wr_en_i;
  logic [7:0]        wr_data_i;
  logic [4:0]        wr_conf_i;
  logic              flush_i;
  logic              full_o, empty_o;
  logic [ADDR_W:0]   count_o;
  logic [7:0]        tx_data_o;
  logic [4:0]        tx_conf_o;
  logic              tx_start_o;
  logic              tx_done_i;
  logic              busy_o;
`ifdef TX_BUFFER_OVERFLOW_EN
  logic              ovf_clr_i;
  logic              overflow_o;
`endif

  tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .wr_conf_i  (wr_conf_i),
    .flush_i    (flush_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .tx_data_o  (tx_data_o),
    .tx_conf_o  (tx_conf_o),
    .tx_start_o (tx_start_o),
    .tx_done_i  (tx_done_i),
    .busy_o     (busy_o)
`ifdef TX_BUFFER_OVERFLOW_EN
    ,
    .ovf_clr_i  (ovf_clr_i),
    .overflow_o (overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference: queue of stored entries plus the one frame being transmitted.
  logic [12:0] mq [$];
  bit          m_act;
  logic [7:0]  m_data;
  logic [4:0]  m_conf;
  bit          m_done_q;
  bit          m_ovf;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    logic [4:0] c;
    bit         fl;
    bit         dn;
    bit         e_start;
    logic [7:0] e_data;
    logic [4:0] e_conf;
    int         e_count;
    bit         e_empty;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_act    = 0;
    m_data   = '0;
    m_conf   = '0;
    m_done_q = 0;
    m_ovf    = 0;
  endtask

  task automatic model_update(input bit wr, input logic [7:0] d, input logic [4:0] c,
                              input bit fl, input bit dn, input bit clr);
    bit          full, empty, rise;
    logic [12:0] e;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    rise  = dn && !m_done_q;
    if (m_act) begin
      if (rise) begin
        if (!fl && !empty) begin
          e = mq.pop_front();
          m_data = e[7:0];
          m_conf = e[12:8];
        end else begin
          m_act = 0;
        end
      end
    end else if (!fl && !empty) begin
      e = mq.pop_front();
      m_data = e[7:0];
      m_conf = e[12:8];
      m_act  = 1;
    end
    if (fl) mq.delete();
    else if (wr && !full) mq.push_back({c, d});
    if (wr && full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_done_q = dn;
  endtask

  task automatic compare_all();
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("tx_start", 32'(tx_start_o), 32'(m_act));
    chk("busy", 32'(busy_o), 32'(m_act));
    chk("tx_data", 32'(tx_data_o), 32'(m_data));
    chk("tx_conf", 32'(tx_conf_o), 32'(m_conf));
`ifdef TX_BUFFER_OVERFLOW_EN
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
`endif
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input logic [4:0] c,
                      input bit fl, input bit dn, input bit clr);
    wr_en_i   = wr;
    wr_data_i = d;
    wr_conf_i = c;
    flush_i   = fl;
    tx_done_i = dn;
`ifdef TX_BUFFER_OVERFLOW_EN
    ovf_clr_i = clr;
`endif
    @(posedge clk_i);
    model_update(wr, d, c, fl, dn, clr);
    #1;
    compare_all();
  endtask

  initial begin
    bit dn_r;
    tv[0] = '{1, 8'hA5, 5'b11011, 0, 0, 0, 8'h00, 5'h00, 1, 0};
    tv[1] = '{0, 8'h00, 5'h00,    0, 0, 1, 8'hA5, 5'h1B, 0, 1};
    tv[2] = '{0, 8'h00, 5'h00,    0, 1, 0, 8'hA5, 5'h1B, 0, 1};
    tv[3] = '{0, 8'h00, 5'h00,    0, 1, 0, 8'hA5, 5'h1B, 0, 1};
    tv[4] = '{1, 8'h3C, 5'h05,    0, 1, 0, 8'hA5, 5'h1B, 1, 0};
    tv[5] = '{0, 8'h00, 5'h00,    0, 1, 1, 8'h3C, 5'h05, 0, 1};
    tv[6] = '{0, 8'h00, 5'h00,    0, 1, 1, 8'h3C, 5'h05, 0, 1};
    tv[7] = '{0, 8'h00, 5'h00,    0, 0, 1, 8'h3C, 5'h05, 0, 1};
    tv[8] = '{0, 8'h00, 5'h00,    0, 1, 0, 8'h3C, 5'h05, 0, 1};
    tv[9] = '{0, 8'h00, 5'h00,    1, 0, 0, 8'h3C, 5'h05, 0, 1};

    rstn_i = 1'b0; wr_en_i = 0; wr_data_i = 0; wr_conf_i = 0; flush_i = 0; tx_done_i = 0;
`ifdef TX_BUFFER_OVERFLOW_EN
    ovf_clr_i = 0;
`endif
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_start", 32'(tx_start_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    chk("rst_conf", 32'(tx_conf_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
`ifdef TX_BUFFER_OVERFLOW_EN
    chk("rst_ovf", 32'(overflow_o), 0);
`endif
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(tv[i].wr, tv[i].d, tv[i].c, tv[i].fl, tv[i].dn, 0);
      chk($sformatf("vec%0d_start", i), 32'(tx_start_o), 32'(tv[i].e_start));
      chk($sformatf("vec%0d_data", i), 32'(tx_data_o), 32'(tv[i].e_data));
      chk($sformatf("vec%0d_conf", i), 32'(tx_conf_o), 32'(tv[i].e_conf));
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tv[i].e_count));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(tv[i].e_empty));
    end

    // Done held high for 16 cycles ends exactly one frame.
    step(1, 8'h11, 5'h02, 0, 0, 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);
    chk("hold_launch", 32'(tx_start_o), 1);
    step(0, 8'h00, 5'h00, 0, 1, 0);
    chk("hold_fall", 32'(tx_start_o), 0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 5'h00, 0, 1, 0);
    chk("hold_idle_busy", 32'(busy_o), 0);
    chk("hold_idle_data", 32'(tx_data_o), 32'h11);
    step(0, 8'h00, 5'h00, 0, 0, 0);

    // Fill with launcher blocked: 0x00 in flight, 0x01..0x10 stored, 0x11 dropped.
    for (int i = 0; i < 18; i++) step(1, 8'(i), 5'(i), 0, 0, 0);
    chk("fill_full", 32'(full_o), 1);
    chk("fill_count", 32'(count_o), 16);
    chk("fill_head", 32'(tx_data_o), 32'h00);
`ifdef TX_BUFFER_OVERFLOW_EN
    chk("ovf_set", 32'(overflow_o), 1);
    step(1, 8'h66, 5'h00, 0, 0, 1);
    chk("ovf_set_wins", 32'(overflow_o), 1);
    step(0, 8'h00, 5'h00, 0, 0, 1);
    chk("ovf_clr", 32'(overflow_o), 0);
`endif
    step(1, 8'h77, 5'h00, 0, 1, 0);
    chk("full_pushpop_count", 32'(count_o), 15);
    chk("full_pushpop_data", 32'(tx_data_o), 32'h01);
    for (int k = 2; k <= 16; k++) begin
      step(0, 8'h00, 5'h00, 0, 0, 0);
      step(0, 8'h00, 5'h00, 0, 1, 0);
      chk($sformatf("drain%0d_data", k), 32'(tx_data_o), 32'(k));
      chk($sformatf("drain%0d_start", k), 32'(tx_start_o), 1);
    end
    step(0, 8'h00, 5'h00, 0, 0, 0);
    step(0, 8'h00, 5'h00, 0, 1, 0);
    chk("drain_end_start", 32'(tx_start_o), 0);
    chk("drain_end_busy", 32'(busy_o), 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);

    // Flush while a frame is in flight with five entries queued.
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 5'(i), 0, 0, 0);
    chk("flq_count", 32'(count_o), 5);
    step(0, 8'h00, 5'h00, 1, 0, 0);
    chk("fl_count", 32'(count_o), 0);
    chk("fl_empty", 32'(empty_o), 1);
    chk("fl_data", 32'(tx_data_o), 32'h40);
    chk("fl_start", 32'(tx_start_o), 1);
    repeat (3) step(0, 8'h00, 5'h00, 0, 0, 0);
    chk("fl_hold_data", 32'(tx_data_o), 32'h40);
    step(0, 8'h00, 5'h00, 0, 1, 0);
    chk("fl_done_start", 32'(tx_start_o), 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);

    // Flush coinciding with done_rise while entries are queued returns to IDLE.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 5'h1F, 0, 0, 0);
    step(0, 8'h00, 5'h00, 1, 1, 0);
    chk("fldone_start", 32'(tx_start_o), 0);
    chk("fldone_count", 32'(count_o), 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);

    // Random traffic against the queue model.
    dn_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) dn_r = ~dn_r;
      step(bit'($urandom_range(1)), 8'($urandom), 5'($urandom),
           ($urandom_range(40) == 0), dn_r, ($urandom_range(10) == 0));
    end

    // Reset mid-frame drops tx_start_o without a clock edge.
    step(0, 8'h00, 5'h00, 0, 0, 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);
    step(1, 8'h99, 5'h0A, 0, 0, 0);
    step(1, 8'h9A, 5'h0B, 0, 0, 0);
    step(0, 8'h00, 5'h00, 0, 0, 0);
    chk("pre_rst_start", 32'(tx_start_o), 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_start", 32'(tx_start_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_count", 32'(count_o), 0);
    chk("arst_data", 32'(tx_data_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    step(0, 8'h00, 5'h00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
